// File: rtl/sample_iter_pkg.sv
// Shared types and helpers for the sample iterator: FSM states, the subsample
// one-hot codes, and the bounding-box corner indices.
package sample_iter_pkg;

   typedef enum logic {
      WAIT = 1'b0,
      TEST = 1'b1
   } iter_state_t;

   localparam int LL = 0;
   localparam int UR = 1;

   localparam logic [3:0] SS_1X  = 4'b0001;
   localparam logic [3:0] SS_4X  = 4'b0010;
   localparam logic [3:0] SS_16X = 4'b0100;
   localparam logic [3:0] SS_64X = 4'b1000;

   // Right-shift applied to the one-pixel step; anything that is not one-hot falls back to 1x.
   function automatic int subsample_shift(input logic [3:0] ss);
      case (ss)
         SS_4X:   return 1;
         SS_16X:  return 2;
         SS_64X:  return 3;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/sample_iter_advance.sv
// Combinational next-position unit: raw x/y increments, the row-wrap decision
// and the last-sample flag, all compared one bit wider so x+step cannot wrap.
module sample_iter_advance #(
   parameter int SIGFIG = 24
) (
   input  logic [2*SIGFIG-1:0] sample,
   input  logic [2*SIGFIG-1:0] ur,
   input  logic [SIGFIG-1:0]   step,
   output logic [2*SIGFIG-1:0] next_sample,
   output logic                wrap_row,
   output logic                last
);

   logic [SIGFIG-1:0] x, y, ur_x, ur_y;
   logic signed [SIGFIG:0] x_inc, y_inc;
   logic x_fits, y_fits;

   assign x    = sample[SIGFIG-1:0];
   assign y    = sample[2*SIGFIG-1:SIGFIG];
   assign ur_x = ur[SIGFIG-1:0];
   assign ur_y = ur[2*SIGFIG-1:SIGFIG];

   assign x_inc  = $signed({x[SIGFIG-1], x}) + $signed({1'b0, step});
   assign y_inc  = $signed({y[SIGFIG-1], y}) + $signed({1'b0, step});
   assign x_fits = x_inc <= $signed({ur_x[SIGFIG-1], ur_x});
   assign y_fits = y_inc <= $signed({ur_y[SIGFIG-1], ur_y});

   assign wrap_row    = !x_fits && y_fits;
   assign last        = !x_fits && !y_fits;
   assign next_sample = {y_inc[SIGFIG-1:0], x_inc[SIGFIG-1:0]};

endmodule

// File: rtl/sample_iterator.sv
// Walks every sample of a triangle's bounding box in raster order, one per unstalled cycle.
// Optional multisample stepping is enabled by defining SAMPLE_ITER_MSAA_EN.
module sample_iterator
   import sample_iter_pkg::*;
#(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_R13S,
   input  logic [COLORS*SIGFIG-1:0]      color_R13U,
   input  logic [4*SIGFIG-1:0]           box_R13S,
   input  logic                          validTri_R13H,
`ifdef SAMPLE_ITER_MSAA_EN
   input  logic [3:0]                    subSample_R13U,
`endif
   output logic                          readyTri_R13H,
   input  logic                          stall_R14H,
   output logic [VERTS*AXIS*SIGFIG-1:0]  tri_R14S,
   output logic [COLORS*SIGFIG-1:0]      color_R14U,
   output logic [2*SIGFIG-1:0]           sample_R14S,
   output logic                          validSamp_R14H,
   output logic                          lastSamp_R14H
);

   localparam logic [SIGFIG-1:0] STEP_1X = SIGFIG'(1) << RADIX;

   iter_state_t state, state_next;

   logic [2*SIGFIG-1:0] ll_in, ur_in, ur_q;
   logic [SIGFIG-1:0]   ll_x_q, step_q;
   logic [2*SIGFIG-1:0] cur_next;
   logic                cur_wrap, cur_last;
   logic                accept, box_ok, load, advance, finish;

   assign ll_in = box_R13S[LL*2*SIGFIG +: 2*SIGFIG];
   assign ur_in = box_R13S[UR*2*SIGFIG +: 2*SIGFIG];

   assign box_ok = ($signed(ur_in[SIGFIG-1:0]) >= $signed(ll_in[SIGFIG-1:0])) &&
                   ($signed(ur_in[2*SIGFIG-1:SIGFIG]) >= $signed(ll_in[2*SIGFIG-1:SIGFIG]));

   assign readyTri_R13H = (state == WAIT) && rst;
   assign accept        = validTri_R13H && readyTri_R13H;

   sample_iter_advance #(.SIGFIG(SIGFIG)) u_advance (
      .sample      (sample_R14S),
      .ur          (ur_q),
      .step        (step_q),
      .next_sample (cur_next),
      .wrap_row    (cur_wrap),
      .last        (cur_last)
   );

   // The last flag comes straight from the held sample, so it holds under stall for free.
   assign lastSamp_R14H = validSamp_R14H && cur_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= WAIT;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      case (state)
         WAIT: begin
            if (accept && box_ok) begin
               load       = 1'b1;
               state_next = TEST;
            end
         end
         TEST: begin
            if (!stall_R14H) begin
               if (cur_last) begin
                  finish     = 1'b1;
                  state_next = WAIT;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_next = WAIT;
      endcase
   end

`ifdef SAMPLE_ITER_MSAA_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        step_q <= STEP_1X;
      else if (accept) step_q <= STEP_1X >> subsample_shift(subSample_R13U);
   end
`else
   assign step_q = STEP_1X;
`endif

   // Triangle and box are captured on any accept; an inverted box is simply never walked.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tri_R14S       <= '0;
         color_R14U     <= '0;
         ll_x_q         <= '0;
         ur_q           <= '0;
         sample_R14S    <= '0;
         validSamp_R14H <= 1'b0;
      end else begin
         if (accept) begin
            tri_R14S   <= tri_R13S;
            color_R14U <= color_R13U;
            ll_x_q     <= ll_in[SIGFIG-1:0];
            ur_q       <= ur_in;
         end
         if (load) begin
            sample_R14S    <= ll_in;
            validSamp_R14H <= 1'b1;
         end else if (advance) begin
            if (cur_wrap) sample_R14S <= {cur_next[2*SIGFIG-1:SIGFIG], ll_x_q};
            else          sample_R14S <= {sample_R14S[2*SIGFIG-1:SIGFIG], cur_next[SIGFIG-1:0]};
         end else if (finish) begin
            validSamp_R14H <= 1'b0;
         end
      end
   end

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
Controller that sequences the sample-test datapath. It accepts one triangle plus its bounding box from the setup stage and walks every sample position inside the box in raster order, one per cycle. Each sample goes to the sample-test stage with the triangle and color held stable. A valid/ready handshake applies upstream and a stall input applies downstream, so the rasterizer pipeline can back-pressure.

Parameters:
SIGFIG, 24, bits in color and position (signed fixed point)
RADIX, 10, fraction bits; one pixel = 1<<RADIX
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
tri_R13S  input  VERTS*AXIS*SIGFIG  triangle vertices
color_R13U  input  COLORS*SIGFIG  triangle color
box_R13S  input  2*2*SIGFIG  bounding box; [0]=lower-left (x,y), [1]=upper-right (x,y)
validTri_R13H  input  1  upstream triangle valid
readyTri_R13H  output  1  iterator idle, accepts triangle this cycle
stall_R14H  input  1  downstream stall; hold all R14 outputs
tri_R14S  output  VERTS*AXIS*SIGFIG  latched triangle
color_R14U  output  COLORS*SIGFIG  latched color
sample_R14S  output  2*SIGFIG  current sample (x,y)
validSamp_R14H  output  1  sample_R14S valid
lastSamp_R14H  output  1  current sample is final one of triangle

Behaviour:
- Reset (rst low, async): state=WAIT; validSamp_R14H=0, lastSamp_R14H=0, sample/tri/color=0. readyTri_R13H forced 0 while rst low.
- States: WAIT, TEST. readyTri_R13H = (state==WAIT) && rst high, combinational from the state register.
- WAIT: on validTri && readyTri, latch tri, color, box and step.
  - If box is valid (ur.x>=ll.x and ur.y>=ll.y): sample<=ll, validSamp<=1, go to TEST.
  - Else (inverted box): drop the triangle, stay in WAIT, emit no samples.
- TEST with stall_R14H=1: all outputs and state hold.
- TEST with stall_R14H=0: advance.
  - If x+step <= ur.x: x+=step.
  - Else if y+step <= ur.y: x=ll.x, y+=step.
  - Else: validSamp<=0, lastSamp<=0, go to WAIT.
- lastSamp_R14H=1 exactly when the presented sample has x+step>ur.x and y+step>ur.y.
- Comparisons are computed at SIGFIG+1 bits signed, so x+step never wraps near the maximum coordinate.
- Latency: triangle accepted at edge N; first sample valid after edge N. Throughput is one sample per unstalled cycle. A new triangle can be accepted in the cycle after the last sample is consumed, so there is a 1-cycle bubble.
- Degenerate box (ll==ur): exactly one sample, with lastSamp=1.
- readyTri does not depend on stall_R14H.
- Reset asserted mid-triangle: iteration is aborted and the triangle is discarded; after release the block is in WAIT.
- Without the optional feature, step = 1<<RADIX.

Optional Feature:
SAMPLE_ITER_MSAA_EN.
- Defined: adds input subSample_R13U [3:0], one-hot {64x,16x,4x,1x}, latched on triangle accept.
  - step = 1<<(RADIX-k), k=0..3, for 1x/4x/16x/64x.
  - A non-one-hot value is treated as 1x.
- Undefined: the port is absent and step is the constant 1<<RADIX.

Decomposition:
- Package sample_iter_pkg holds:
  - iter_state_t enum {WAIT, TEST}
  - subsample one-hot encoding constants
  - a step-from-subsample function
  - a box-index localparam (LL=0, UR=1)
- Sub-module sample_iter_advance: combinational next-position unit. It takes the current sample, box and step, and produces next_sample, wrap_row and last. It is reused for both the advance logic and the lastSamp flag.

Test Plan:
- box ll=(0,0), ur=(2048,1024), 1x, no stall -> 6 samples: (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024); lastSamp only on the 6th; readyTri=1 the following cycle.
- box ll=ur=(3072,5120) -> single sample (3072,5120) with validSamp=1 and lastSamp=1 for one cycle, then WAIT.
- box ll=(1024,0), ur=(0,0) (inverted) -> no validSamp; readyTri stays 1; the next triangle is accepted the next cycle.
- stall_R14H=1 for 3 cycles while sample=(1024,0) -> sample, validSamp and tri hold for 4 cycles; the sequence resumes at (2048,0) with no sample lost or duplicated.
- rst low during the 3rd sample -> validSamp=0 immediately (async); after release readyTri=1 and the state is WAIT.
- SAMPLE_ITER_MSAA_EN, subSample=4'b0010 (4x), box (0,0)-(1024,0) -> x=0,512,1024 at step 512; lastSamp on x=1024.
